// File: rtl/score_keeper_pkg.sv
// Shared constants for the score keeper: default point values, level step,
// BCD digit width, FSM state encoding and the points-times-level helper.
package score_keeper_pkg;

    localparam int DEF_PTS_1         = 1;
    localparam int DEF_PTS_2         = 3;
    localparam int DEF_PTS_3         = 5;
    localparam int DEF_PTS_4         = 8;
    localparam int DEF_LINES_PER_LVL = 10;

    localparam int DIGIT_W     = 4;
    localparam int CLR_LINES_W = 3;
    localparam int PENDING_W   = 6;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ADD  = 1'b1;

    // base * (lvl + 1) built from shifts and one add so no multiplier is inferred.
    function automatic logic [PENDING_W-1:0] scale_by_level(input logic [PENDING_W-1:0] base,
                                                            input logic [1:0]           lvl);
        case (lvl)
            2'd0:    return base;
            2'd1:    return base << 1;
            2'd2:    return base + (base << 1);
            default: return base << 2;
        endcase
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Line-clear event handshake between the settling logic (master) and the
// score keeper (slave).
//   clr_valid  master -> slave  event offered
//   clr_lines  master -> slave  lines cleared by the event
//   clr_ready  slave  -> master event can be accepted this cycle
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic                   clr_valid;
    logic [CLR_LINES_W-1:0] clr_lines;
    logic                   clr_ready;

    modport master (output clr_valid, output clr_lines, input clr_ready);
    modport slave  (input clr_valid, input clr_lines, output clr_ready);

endinterface

// File: rtl/score_keeper_bcd_digit.sv
// One decade counter (bcd_digit) of the score chain.
//   clk, resetn  clock and async active-low reset
//   clear        synchronous clear to 0, wins over inc_in
//   inc_in       count up by one this cycle
//   carry_out    inc_in while the digit is at 9 (digit wraps to 0)
//   q            current digit, always 0..9
module score_keeper_bcd_digit
    import score_keeper_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               inc_in,
    output logic               carry_out,
    output logic [DIGIT_W-1:0] q
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (inc_in) begin
            q_d = (q_q >= BCD_MAX) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign carry_out = inc_in && (q_q == BCD_MAX);
    assign q         = q_q;

endmodule

// File: rtl/score_keeper.sv
// Score keeper: accepts line-clear events, adds PTS_n * (level+1) points to a
// 4-digit BCD score one unit per clock, and steps the fall-speed level every
// LINES_PER_LVL cleared lines.
//   clk          system clock
//   resetn       async active-low reset
//   game_reset   synchronous new-game clear
//   clr_if       line-clear event handshake (slave side)
//   score_*      BCD score digits, thousands..units
//   level        speed level 0..3
//   saturated    score has hit 9999
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for an event, clr_ready high
//   ADD   | rippling pending points into the score, 1/clk
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int PTS_1         = DEF_PTS_1,
    parameter int PTS_2         = DEF_PTS_2,
    parameter int PTS_3         = DEF_PTS_3,
    parameter int PTS_4         = DEF_PTS_4,
    parameter int LINES_PER_LVL = DEF_LINES_PER_LVL
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               game_reset,
    score_keeper_if.slave      clr_if,
    output logic [DIGIT_W-1:0] score_thsnd,
    output logic [DIGIT_W-1:0] score_hndrd,
    output logic [DIGIT_W-1:0] score_tens,
    output logic [DIGIT_W-1:0] score_units,
    output logic [1:0]         level,
    output logic               saturated
);

    logic [0:0]           state_q,   state_d;
    logic [PENDING_W-1:0] pending_q, pending_d;
    logic [3:0]           tally_q,   tally_d;
    logic [1:0]           level_q,   level_d;
    logic                 sat_q,     sat_d;

    logic [4:0]           tally_sum;
    logic [PENDING_W-1:0] base_pts;
    logic                 lines_ok;
    logic                 accept;
    logic                 all_nines;
    logic                 inc_units;
    logic [3:0]           carry;
    logic [DIGIT_W-1:0]   digit [4];

    // resetn in the ready term keeps clr_ready low for the whole reset pulse.
    assign clr_if.clr_ready = resetn && (state_q == ST_IDLE) && !game_reset;
    assign accept           = clr_if.clr_valid && clr_if.clr_ready;
    assign lines_ok         = (clr_if.clr_lines >= 3'd1) && (clr_if.clr_lines <= 3'd4);

    always_comb begin
        case (clr_if.clr_lines)
            3'd1:    base_pts = PENDING_W'(PTS_1);
            3'd2:    base_pts = PENDING_W'(PTS_2);
            3'd3:    base_pts = PENDING_W'(PTS_3);
            3'd4:    base_pts = PENDING_W'(PTS_4);
            default: base_pts = '0;
        endcase
    end

    assign all_nines = (digit[0] == BCD_MAX) && (digit[1] == BCD_MAX) &&
                       (digit[2] == BCD_MAX) && (digit[3] == BCD_MAX);
    assign inc_units = (state_q == ST_ADD) && !all_nines && !game_reset;

    // digit[0] = units ... digit[3] = thousands; each carry feeds the next decade.
    for (genvar g = 0; g < 4; g++) begin : g_digit
        score_keeper_bcd_digit u_digit (
            .clk       (clk),
            .resetn    (resetn),
            .clear     (game_reset),
            .inc_in    ((g == 0) ? inc_units : carry[(g == 0) ? 0 : g - 1]),
            .carry_out (carry[g]),
            .q         (digit[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tally_d   = tally_q;
        level_d   = level_q;
        sat_d     = sat_q;
        tally_sum = {1'b0, tally_q} + {2'b00, clr_if.clr_lines};

        if (game_reset) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            tally_d   = '0;
            level_d   = '0;
            sat_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Out-of-range line counts are consumed without effect.
                    if (accept && lines_ok) begin
                        pending_d = scale_by_level(base_pts, level_q);
                        state_d   = ST_ADD;
                        if (tally_sum >= 5'(LINES_PER_LVL)) begin
                            tally_d = 4'(tally_sum - 5'(LINES_PER_LVL));
                            if (level_q != 2'd3) begin
                                level_d = level_q + 2'd1;
                            end
                        end else begin
                            tally_d = tally_sum[3:0];
                        end
                    end
                end
                default: begin
                    if (all_nines) begin
                        sat_d     = 1'b1;
                        pending_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        pending_d = pending_q - 1'b1;
                        if (pending_q == PENDING_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
            // Thousands carry can only appear on a 9999 wrap, which the gated
            // chain never performs; treat it as saturation regardless.
            if (carry[3]) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            tally_q   <= '0;
            level_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tally_q   <= tally_d;
            level_q   <= level_d;
            sat_q     <= sat_d;
        end
    end

    assign score_units = digit[0];
    assign score_tens  = digit[1];
    assign score_hndrd = digit[2];
    assign score_thsnd = digit[3];
    assign level       = level_q;
    assign saturated   = sat_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    localparam int LPL = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       game_reset;
    logic [3:0] th, hu, te, un;
    logic [1:0] level;
    logic       saturated;

    always #5 clk = ~clk;

    score_keeper_if sk_if ();

    score_keeper dut (
        .clk         (clk),
        .resetn      (resetn),
        .game_reset  (game_reset),
        .clr_if      (sk_if.slave),
        .score_thsnd (th),
        .score_hndrd (hu),
        .score_tens  (te),
        .score_units (un),
        .level       (level),
        .saturated   (saturated)
    );

    typedef struct {
        int score;
        int lvl;
        int sat;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_score, m_level, m_tally, m_sat;

    function automatic int base_pts(input int n);
        case (n)
            1:       return 1;
            2:       return 3;
            3:       return 5;
            4:       return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected DUT response", tag);
    endtask

    task automatic model_clear();
        m_score = 0;
        m_level = 0;
        m_tally = 0;
        m_sat   = 0;
    endtask

    // Offer one event, update the bench model and queue the expected outcome.
    task automatic start_event(input int n);
        int   t;
        int   pts;
        int   room;
        exp_t e;
        t = 0;
        while (sk_if.clr_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) bound_fail("ready_wait");
        pts = base_pts(n) * (m_level + 1);
        if (pts == 0) begin
            e.busy = 0;
        end else begin
            room = 9999 - m_score;
            if (pts > room) begin
                e.busy  = room + 1;
                m_score = 9999;
                m_sat   = 1;
            end else begin
                e.busy  = pts;
                m_score = m_score + pts;
            end
            m_tally = m_tally + n;
            if (m_tally >= LPL) begin
                m_tally = m_tally - LPL;
                if (m_level < 3) m_level++;
            end
        end
        e.score = m_score;
        e.lvl   = m_level;
        e.sat   = m_sat;
        sb.push_back(e);
        sk_if.clr_valid = 1'b1;
        sk_if.clr_lines = 3'(n);
        @(negedge clk);
        sk_if.clr_valid = 1'b0;
    endtask

    task automatic finish_event(input string tag);
        int   busy;
        exp_t e;
        busy = 0;
        while (sk_if.clr_ready === 1'b0 && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= 200) bound_fail({tag, "_done"});
        e = sb.pop_front();
        check({tag, "_busy"},  busy, e.busy);
        check({tag, "_score"}, {th, hu, te, un}, to_bcd(e.score));
        check({tag, "_level"}, level, e.lvl);
        check({tag, "_sat"},   saturated, e.sat);
    endtask

    task automatic do_game_reset(input string tag);
        @(negedge clk);
        game_reset = 1'b1;
        #1;
        check({tag, "_ready_low"}, sk_if.clr_ready, 1'b0);
        @(negedge clk);
        game_reset = 1'b0;
        model_clear();
        check({tag, "_score"}, {th, hu, te, un}, 16'h0000);
        check({tag, "_level"}, level, 2'd0);
        check({tag, "_sat"},   saturated, 1'b0);
        #1;
        check({tag, "_ready_high"}, sk_if.clr_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pre;
        int rem;
        int n;
        resetn          = 1'b0;
        game_reset      = 1'b0;
        sk_if.clr_valid = 1'b0;
        sk_if.clr_lines = 3'd0;
        model_clear();

        #3;
        check("rst_score", {th, hu, te, un}, 16'h0000);
        check("rst_level", level, 2'd0);
        check("rst_sat",   saturated, 1'b0);
        check("rst_ready", sk_if.clr_ready, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", sk_if.clr_ready, 1'b1);

        start_event(1); finish_event("single");
        do_game_reset("gr1");

        start_event(4); finish_event("lvl_a");
        start_event(4); finish_event("lvl_b");
        start_event(4); finish_event("lvl_c");
        start_event(2); finish_event("double_l1");

        start_event(0); finish_event("lines0");
        start_event(6); finish_event("lines6");

        // Walk through 99 -> 100 while levels climb to 3.
        start_event(4); finish_event("carry_a");
        start_event(4); finish_event("carry_b");
        start_event(4); finish_event("carry_c");
        start_event(4); finish_event("carry_d");

        // game_reset in the middle of a 32-point add, with clr_valid held.
        pre = m_score;
        start_event(4);
        repeat (12) @(negedge clk);
        check("mid_add_score", {th, hu, te, un}, to_bcd(pre + 12));
        game_reset      = 1'b1;
        sk_if.clr_valid = 1'b1;
        sk_if.clr_lines = 3'd4;
        #1;
        check("gr_mid_ready", sk_if.clr_ready, 1'b0);
        @(negedge clk);
        check("gr_mid_score", {th, hu, te, un}, 16'h0000);
        check("gr_mid_level", level, 2'd0);
        check("gr_mid_sat",   saturated, 1'b0);
        game_reset      = 1'b0;
        sk_if.clr_valid = 1'b0;
        #1;
        check("gr_mid_idle", sk_if.clr_ready, 1'b1);
        @(negedge clk);
        check("gr_mid_dropped", {th, hu, te, un}, 16'h0000);
        check("gr_mid_ready2",  sk_if.clr_ready, 1'b1);
        sb.delete();
        model_clear();

        // Async reset in the middle of an add, between clock edges.
        start_event(4);
        repeat (3) @(negedge clk);
        check("arst_pre_score", {th, hu, te, un}, 16'h0003);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_score", {th, hu, te, un}, 16'h0000);
        check("arst_level", level, 2'd0);
        check("arst_sat",   saturated, 1'b0);
        check("arst_ready", sk_if.clr_ready, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        model_clear();
        @(negedge clk);
        check("arst_release_ready", sk_if.clr_ready, 1'b1);

        // Climb to 9995: three single lines first so the level-3 remainder is a multiple of 4.
        repeat (3) begin
            start_event(1); finish_event("climb_pre");
        end
        for (int it = 0; it < 1000 && m_score < 9995; it++) begin
            rem = 9995 - m_score;
            n   = 0;
            for (int k = 4; k >= 1; k--) begin
                if (n == 0 && base_pts(k) * (m_level + 1) <= rem) n = k;
            end
            if (n == 0) begin
                bound_fail("climb_plan");
                break;
            end
            start_event(n);
            finish_event("climb");
        end
        check("climb_end_score", {th, hu, te, un}, 16'h9995);
        check("climb_end_level", level, 2'd3);

        start_event(4); finish_event("saturate");
        start_event(1); finish_event("post_sat");

        do_game_reset("gr_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
